alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a valid/ready handshake on both sides. Shifts run one bit per
// cycle and every other operation completes in a single cycle.
module alu_seq #(
   parameter int XLEN       = 32,
   parameter int SHAMT_W    = 5,
   parameter int ALU_OP_LEN = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_OP_LEN-1:0] alu_op,
   input  logic [XLEN-1:0]       srca,
   input  logic [XLEN-1:0]       srcb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       result,
   output logic                  zero
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SH_LEFT, SH_RIGHT_LOGIC, SH_RIGHT_ARITH} shift_t;

   localparam logic [ALU_OP_LEN-1:0] OP_ADD  = ALU_OP_LEN'(0);
   localparam logic [ALU_OP_LEN-1:0] OP_SUB  = ALU_OP_LEN'(1);
   localparam logic [ALU_OP_LEN-1:0] OP_SLL  = ALU_OP_LEN'(2);
   localparam logic [ALU_OP_LEN-1:0] OP_SLT  = ALU_OP_LEN'(3);
   localparam logic [ALU_OP_LEN-1:0] OP_SLTU = ALU_OP_LEN'(4);
   localparam logic [ALU_OP_LEN-1:0] OP_XOR  = ALU_OP_LEN'(5);
   localparam logic [ALU_OP_LEN-1:0] OP_SRL  = ALU_OP_LEN'(6);
   localparam logic [ALU_OP_LEN-1:0] OP_SRA  = ALU_OP_LEN'(7);
   localparam logic [ALU_OP_LEN-1:0] OP_OR   = ALU_OP_LEN'(8);
   localparam logic [ALU_OP_LEN-1:0] OP_AND  = ALU_OP_LEN'(9);

   state_t              state;
   shift_t              shift_kind;
   shift_t              shift_kind_next;
   logic [SHAMT_W-1:0]  cnt;
   logic [SHAMT_W-1:0]  shamt;
   logic [XLEN-1:0]     op_result;
   logic [XLEN-1:0]     shifted;
   logic                is_shift;
   logic                accept;

   assign shamt  = srcb[SHAMT_W-1:0];
   assign accept = in_valid && in_ready;
   assign zero   = (result == '0);

   // Single-cycle datapath; shift opcodes pass srca through as the preload value.
   always_comb begin
      // NOTE: every output of this block is given a default first, so no path infers a latch.
      op_result       = '0;
      is_shift        = 1'b0;
      shift_kind_next = SH_LEFT;
      case (alu_op)
         OP_ADD:  op_result = srca + srcb;
         OP_SUB:  op_result = srca - srcb;
         OP_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
         OP_SLTU: op_result = {{(XLEN-1){1'b0}}, (srca < srcb)};
         OP_XOR:  op_result = srca ^ srcb;
         OP_OR:   op_result = srca | srcb;
         OP_AND:  op_result = srca & srcb;
         OP_SLL: begin
            op_result       = srca;
            is_shift        = 1'b1;
            shift_kind_next = SH_LEFT;
         end
         OP_SRL: begin
            op_result       = srca;
            is_shift        = 1'b1;
            shift_kind_next = SH_RIGHT_LOGIC;
         end
         OP_SRA: begin
            op_result       = srca;
            is_shift        = 1'b1;
            shift_kind_next = SH_RIGHT_ARITH;
         end
         default: op_result = '0;
      endcase
   end

   always_comb begin
      shifted = result;
      case (shift_kind)
         SH_LEFT:        shifted = {result[XLEN-2:0], 1'b0};
         SH_RIGHT_LOGIC: shifted = {1'b0, result[XLEN-1:1]};
         SH_RIGHT_ARITH: shifted = {result[XLEN-1], result[XLEN-1:1]};
         default:        shifted = result;
      endcase
   end

   // in_ready and out_valid are registered and track the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_kind <= SH_LEFT;
         cnt        <= '0;
         result     <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register here sees pre-edge values.
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  in_ready <= 1'b0;
                  result   <= op_result;
                  if (is_shift && (shamt != '0)) begin
                     cnt        <= shamt;
                     shift_kind <= shift_kind_next;
                     state      <= SHIFT;
                  end else begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            SHIFT: begin
               result <= shifted;
               cnt    <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: latency-countdown reference model with a per-cycle
// compare, directed literal cases, then randomized traffic with occasional resets.
module tb_alu_seq;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] srca;
   logic [XLEN-1:0] srcb;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: readiness, pending result and remaining cycles to valid.
   logic            m_ready  = 1'b0;
   logic            m_valid  = 1'b0;
   logic            m_busy   = 1'b0;
   logic            m_clean  = 1'b1;
   logic [XLEN-1:0] m_result = '0;
   int              m_wait   = 0;

   alu_seq #(.XLEN(32), .SHAMT_W(5), .ALU_OP_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .srca      (srca),
      .srcb      (srcb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << b[4:0];
         4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> b[4:0];
         4'd7:    return $signed(a) >>> b[4:0];
         4'd8:    return a | b;
         4'd9:    return a & b;
         default: return '0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [XLEN-1:0] b);
      if (op == 4'd2 || op == 4'd6 || op == 4'd7) return 1 + int'(b[4:0]);
      return 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready <= 1'b0;
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
         m_wait  <= 0;
         m_clean <= 1'b1;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
         end
      end else if (m_busy) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
         end
      end else if (m_ready && in_valid) begin
         m_ready  <= 1'b0;
         m_clean  <= 1'b0;
         m_result <= ref_result(alu_op, srca, srcb);
         if (ref_latency(alu_op, srcb) == 1) begin
            m_valid <= 1'b1;
         end else begin
            m_busy <= 1'b1;
            m_wait <= ref_latency(alu_op, srcb) - 1;
         end
      end else begin
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      check("cyc_in_ready", in_ready, m_ready);
      check("cyc_out_valid", out_valid, m_valid);
      if (m_valid) begin
         check("cyc_result", result, m_result);
         check("cyc_zero", zero, m_result == '0);
      end else if (m_clean) begin
         check("cyc_reset_result", result, 0);
         check("cyc_reset_zero", zero, 1);
      end
   end

   function automatic logic [XLEN-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, keep junk on the inputs while busy, then hold the result before handshaking.
   task automatic do_op(input string name, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int hold,
                        input logic [XLEN-1:0] exp_res, input int exp_lat);
      int guard;
      int lat;
      guard = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({name, "_ready"}, in_ready, 1);
      alu_op    = op;
      srca      = a;
      srcb      = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      alu_op = 4'($urandom_range(0, 15));
      srca   = $urandom;
      srcb   = $urandom;
      lat    = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         check({name, "_busy_ready"}, in_ready, 0);
         @(negedge clk);
         srca = $urandom;
         srcb = $urandom;
         lat++;
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_result"}, result, exp_res);
      check({name, "_zero"}, zero, exp_res == '0);
      check({name, "_done_ready"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, "_hold_result"}, result, exp_res);
         check({name, "_hold_valid"}, out_valid, 1);
         check({name, "_hold_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_after_valid"}, out_valid, 0);
      check({name, "_after_ready"}, in_ready, 1);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = '0;
      srca      = '0;
      srcb      = '0;
      #1 rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);
      check("post_rst_zero", zero, 1);

      do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1);
      do_op("sra4",     4'd7, 32'h8000_0000, 32'h0000_0024, 0, 32'hF800_0000, 5);
      do_op("slt",      4'd3, 32'hFFFF_FFFF, 32'h0000_0000, 0, 32'h0000_0001, 1);
      do_op("sltu",     4'd4, 32'hFFFF_FFFF, 32'h0000_0000, 0, 32'h0000_0000, 1);
      do_op("sub_hold", 4'd1, 32'h0000_0005, 32'h0000_0007, 3, 32'hFFFF_FFFE, 1);
      do_op("op12",     4'd12, 32'h0000_1234, 32'h0000_5678, 1, 32'h0000_0000, 1);
      do_op("srl31",    4'd6, 32'h8000_0000, 32'h0000_001F, 0, 32'h0000_0001, 32);
      do_op("sll_sh0",  4'd2, 32'hA5A5_A5A5, 32'h0000_0020, 0, 32'hA5A5_A5A5, 1);
      do_op("xor",      4'd5, 32'hF0F0_0F0F, 32'hFF00_FF00, 0, 32'h0FF0_F00F, 1);

      // Long left shift cut short by reset partway through.
      alu_op   = 4'd2;
      srca     = 32'h0000_0001;
      srcb     = 32'h0000_001F;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("sll31_midshift_valid", out_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      check("sll31_rst_valid", out_valid, 0);
      check("sll31_rst_result", result, 0);
      check("sll31_rst_zero", zero, 1);
      check("sll31_rst_ready", in_ready, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      do_op("add_after_rst", 4'd0, 32'h0000_0002, 32'h0000_0003, 0, 32'h0000_0005, 1);

      // Random traffic: the per-cycle compare against the model does the checking.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 1) == 1);
         alu_op    = 4'($urandom_range(0, 15));
         srca      = pick_operand();
         srcb      = pick_operand();
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
